ysyx_24080006_wbu: RTL and testbench
====================================

Name: ysyx_24080006_wbu

Overview:
- Write-back/commit stage of the multi-cycle RV32E core.
- Accepts one retired instruction from the LSU over a valid/ready handshake, then commits it: GPR write, CSR write, and ecall/mret trap handling.
- Hands the next fetch PC to the IFU over a second valid/ready handshake.
- Owns the architectural GPR file and machine CSRs, with combinational read ports for IDU/EXU.

Parameters:
- RESET_PC, 32'h3000_0000, first fetch address issued after reset.
- NR_GPR, 16, number of GPRs (RV32E).

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  LSU has a retired instruction
- in_ready  out  1  WBU can accept
- in_pc  in  32  PC of the retiring instruction
- in_dnpc  in  32  computed next PC
- in_rd_addr  in  5  destination register
- in_wdata  in  32  GPR write data (alu_res/load data)
- in_wb  in  1  GPR write enable
- in_csr_addr  in  12  CSR target
- in_csr_we  in  1  CSR write enable
- in_csr_wdata  in  32  CSR write data
- in_ecall  in  1  environment call
- in_mret  in  1  trap return
- out_valid  out  1  next PC available
- out_ready  in  1  IFU accepts next PC
- out_npc  out  32  next fetch PC
- rs1_addr  in  5  GPR read port 1 address
- rs1_data  out  32  GPR read port 1 data
- rs2_addr  in  5  GPR read port 2 address
- rs2_data  out  32  GPR read port 2 data
- csr_raddr  in  12  CSR read address
- csr_rdata  out  32  CSR read data

Behaviour:
- States: BOOT, IDLE, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state!=IDLE).
  - Both are decoded from the registered state only, never from inputs.
- Reset: state<=BOOT, out_npc<=RESET_PC, all GPRs<=0, mstatus<=32'h1800, mtvec/mepc/mcause<=0.
  - Reset mid-transaction discards any pending commit and returns to BOOT.
- BOOT: out_valid=1 with out_npc=RESET_PC. On out_ready go to IDLE. No commit occurs in BOOT.
- IDLE: on in_valid, the commit happens at that edge and the state moves to DONE (latency 1 cycle).
  - ecall: mepc<=in_pc, mcause<=32'd11, out_npc<=mtvec. in_wb and in_csr_we are suppressed.
  - mret (and not ecall): out_npc<=mepc. in_csr_we is still honoured, in_wb is suppressed.
  - Otherwise: out_npc<=in_dnpc.
    - If in_wb and rd!=0 and rd<16: GPR[rd]<=in_wdata.
    - If in_csr_we: write the CSR.
  - ecall and mret together: ecall wins.
- DONE: hold out_npc stable. On out_ready go to IDLE; otherwise stay and ignore in_valid.
- GPR writes:
  - rd=0 is dropped.
  - rd[4]=1 is dropped; under SIM_MODE it prints a message and calls $finish.
- GPR reads: combinational, with x0 reading 0.
  - rs addresses >=16 read 0.
  - No write-to-read bypass; a read in the commit cycle returns the old value.
- CSR map:
  - Writable: mstatus 12'h300, mtvec 12'h305, mepc 12'h341, mcause 12'h342.
  - Read-only: mvendorid 12'hF11 = 32'h7973_7978, marchid 12'hF12 = 32'd24080006. Writes to these are ignored.
  - Unmapped addresses read 0 and ignore writes.
  - csr_rdata is combinational and shows the pre-commit value during the commit cycle.
- No internal combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package ysyx_24080006_pkg:
  - CSR address localparams: CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MVENDORID, CSR_MARCHID.
  - MCAUSE_ECALL_M = 11.
  - MSTATUS_RESET = 32'h1800.
  - wbu_state_e enum {BOOT, IDLE, DONE}.
- Sub-module ysyx_24080006_regfile:
  - NR_GPR entries, one sync write port, two async read ports, x0 hardwired to 0.
- CSR logic stays inline in the WBU.

Test Plan:
- Boot: release reset with out_ready low for 3 cycles -> out_valid=1, out_npc=32'h3000_0000 held; out_ready=1 -> IDLE, in_ready=1 next cycle.
- GPR write: in_valid, in_rd_addr=5, in_wb=1, in_wdata=32'hDEAD_BEEF, in_dnpc=32'h3000_0004 -> rs1_addr=5 reads 32'hDEAD_BEEF after the edge; out_npc=32'h3000_0004; in_ready=0 until out_ready.
- x0 and illegal rd:
  - rd=0, wdata=32'h1234 -> rs1_data(0)=0.
  - rd=17 (SIM_MODE off) -> no GPR changes.
- CSR/ecall: write mtvec=32'h8000_0100; then ecall at in_pc=32'h8000_0040 with in_wb=1, rd=3 -> mepc=32'h8000_0040, mcause=11, out_npc=32'h8000_0100, x3 unchanged.
- mret: after the ecall -> out_npc=32'h8000_0040; ecall+mret together -> trap taken (out_npc=mtvec).
- Backpressure/reset: hold out_ready=0 in DONE for 5 cycles with in_valid=1 and changing data -> no further commits, out_npc stable; assert reset in DONE -> BOOT, GPRs zero, mstatus=32'h1800.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// Shared definitions for the write-back/commit stage of the RV32E core:
// machine CSR addresses, trap constants and the WBU handshake states.
package ysyx_24080006_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] MSTATUS_RESET  = 32'h0000_1800;
    localparam logic [31:0] MVENDORID_VAL  = 32'h7973_7978;
    localparam logic [31:0] MARCHID_VAL    = 32'd24080006;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        DONE = 2'd2
    } wbu_state_e;

endpackage

// File: rtl/ysyx_24080006_regfile.sv
// Architectural GPR file: one synchronous write port, two combinational
// read ports, x0 hardwired to zero and out-of-range addresses reading zero.
module ysyx_24080006_regfile
    import ysyx_24080006_pkg::*;
#(
    parameter int NR_GPR = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data
);

    localparam int AW = $clog2(NR_GPR);

    logic [31:0] regs [NR_GPR];
    logic        waddr_ok;
    logic        rs1_ok;
    logic        rs2_ok;

    assign waddr_ok = (32'(waddr) < NR_GPR) && (waddr != 5'd0);
    assign rs1_ok   = (32'(rs1_addr) < NR_GPR) && (rs1_addr != 5'd0);
    assign rs2_ok   = (32'(rs2_addr) < NR_GPR) && (rs2_addr != 5'd0);

    // Register array: cleared on reset, writes to x0 or beyond the file are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NR_GPR; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr_ok) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

    // Read ports see the stored value only; a same-cycle write is not forwarded.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_ok) begin
            rs1_data = regs[rs1_addr[AW-1:0]];
        end
        if (rs2_ok) begin
            rs2_data = regs[rs2_addr[AW-1:0]];
        end
    end

`ifdef SIM_MODE
    // Simulation-only trap for a write to a register that RV32E does not have.
    always @(posedge clock) begin
        if (!reset && we && waddr[4]) begin
            $display("regfile: illegal write to x%0d", waddr);
            $finish;
        end
    end
`endif

endmodule

// File: rtl/ysyx_24080006_wbu.sv
// Write-back/commit stage: takes one retired instruction from the LSU,
// commits GPR/CSR updates and ecall/mret traps, and hands the next fetch
// PC to the IFU. Owns the GPR file and the machine CSRs.
module ysyx_24080006_wbu
    import ysyx_24080006_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int          NR_GPR   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_dnpc,
    input  logic [4:0]  in_rd_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_wb,
    input  logic [11:0] in_csr_addr,
    input  logic        in_csr_we,
    input  logic [31:0] in_csr_wdata,
    input  logic        in_ecall,
    input  logic        in_mret,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_npc,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata
);

    wbu_state_e state;
    wbu_state_e state_next;

    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic commit;
    logic take_trap;
    logic take_mret;
    logic gpr_we;
    logic csr_we;

    // A commit happens only on the edge where IDLE sees a valid instruction;
    // ecall takes priority over mret when both are flagged.
    assign commit    = (state == IDLE) && in_valid;
    assign take_trap = commit && in_ecall;
    assign take_mret = commit && !in_ecall && in_mret;
    assign gpr_we    = commit && !in_ecall && !in_mret && in_wb;
    assign csr_we    = commit && !in_ecall && in_csr_we;

    // Handshake outputs come from the registered state alone.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state != IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: BOOT/DONE wait for the IFU to take the PC, IDLE waits for the LSU.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    if (out_ready) state_next = IDLE;
            IDLE:    if (in_valid)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = BOOT;
        endcase
    end

    // Next fetch PC: trap vector, saved return address or the computed dnpc.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_npc <= RESET_PC;
        end else if (take_trap) begin
            out_npc <= mtvec;
        end else if (take_mret) begin
            out_npc <= mepc;
        end else if (commit) begin
            out_npc <= in_dnpc;
        end
    end

    // Machine CSRs: ecall records the trap, otherwise an explicit CSR write lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus <= MSTATUS_RESET;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (take_trap) begin
            mepc   <= in_pc;
            mcause <= MCAUSE_ECALL_M;
        end else if (csr_we) begin
            case (in_csr_addr)
                CSR_MSTATUS: mstatus <= in_csr_wdata;
                CSR_MTVEC:   mtvec   <= in_csr_wdata;
                CSR_MEPC:    mepc    <= in_csr_wdata;
                CSR_MCAUSE:  mcause  <= in_csr_wdata;
                default:     ;
            endcase
        end
    end

    // CSR read port: stored values plus the read-only ID registers, zero elsewhere.
    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS:   csr_rdata = mstatus;
            CSR_MTVEC:     csr_rdata = mtvec;
            CSR_MEPC:      csr_rdata = mepc;
            CSR_MCAUSE:    csr_rdata = mcause;
            CSR_MVENDORID: csr_rdata = MVENDORID_VAL;
            CSR_MARCHID:   csr_rdata = MARCHID_VAL;
            default:       csr_rdata = '0;
        endcase
    end

    ysyx_24080006_regfile #(
        .NR_GPR(NR_GPR)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we       (gpr_we),
        .waddr    (in_rd_addr),
        .wdata    (in_wdata),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data)
    );

endmodule

// File: tb/tb_ysyx_24080006_wbu.sv
// Directed bench for the WBU: boot handshake, a table of commits with
// hand-computed results, then pre-commit visibility, backpressure and reset.
module tb_ysyx_24080006_wbu;
    import ysyx_24080006_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_dnpc;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_wdata;
    logic        in_wb;
    logic [11:0] in_csr_addr;
    logic        in_csr_we;
    logic [31:0] in_csr_wdata;
    logic        in_ecall;
    logic        in_mret;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_npc;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;

    int total;
    int bad;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] dnpc;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        wb;
        logic [11:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wdata;
        logic        ecall;
        logic        mret;
        logic [31:0] exp_npc;
        logic [4:0]  rs1a;
        logic [31:0] exp_rs1;
        logic [4:0]  rs2a;
        logic [31:0] exp_rs2;
        logic [11:0] csra;
        logic [31:0] exp_csra;
        logic [11:0] csrb;
        logic [31:0] exp_csrb;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vec [NVEC];

    ysyx_24080006_wbu dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_dnpc      (in_dnpc),
        .in_rd_addr   (in_rd_addr),
        .in_wdata     (in_wdata),
        .in_wb        (in_wb),
        .in_csr_addr  (in_csr_addr),
        .in_csr_we    (in_csr_we),
        .in_csr_wdata (in_csr_wdata),
        .in_ecall     (in_ecall),
        .in_mret      (in_mret),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_npc      (out_npc),
        .rs1_addr     (rs1_addr),
        .rs1_data     (rs1_data),
        .rs2_addr     (rs2_addr),
        .rs2_data     (rs2_data),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_pc        = v.pc;
        in_dnpc      = v.dnpc;
        in_rd_addr   = v.rd;
        in_wdata     = v.wdata;
        in_wb        = v.wb;
        in_csr_addr  = v.csr_addr;
        in_csr_we    = v.csr_we;
        in_csr_wdata = v.csr_wdata;
        in_ecall     = v.ecall;
        in_mret      = v.mret;
    endtask

    task automatic readCsr(input logic [11:0] a, output logic [31:0] d);
        csr_raddr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic readGpr(input logic [4:0] a, output logic [31:0] d);
        rs1_addr = a;
        #1;
        d = rs1_data;
    endtask

    task automatic releaseDone(input string name);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        checkOutput({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        vec_t idle_v;
        total = 0;
        bad   = 0;

        //                pc            dnpc          rd     wdata         wb    csr_addr       we    csr_wdata     ec    mr    exp_npc       rs1a   exp_rs1       rs2a   exp_rs2       csra           exp_csra      csrb           exp_csrb
        vec[0]  = '{32'h3000_0000, 32'h3000_0004, 5'd5,  32'hDEAD_BEEF, 1'b1, 12'h000,       1'b0, 32'h0,        1'b0, 1'b0, 32'h3000_0004, 5'd5,  32'hDEAD_BEEF, 5'd0,  32'h0,        CSR_MSTATUS,   32'h1800,     CSR_MTVEC,     32'h0};
        vec[1]  = '{32'h3000_0004, 32'h3000_0008, 5'd0,  32'h0000_1234, 1'b1, 12'h000,       1'b0, 32'h0,        1'b0, 1'b0, 32'h3000_0008, 5'd0,  32'h0,         5'd5,  32'hDEAD_BEEF, CSR_MEPC,      32'h0,        CSR_MCAUSE,    32'h0};
        vec[2]  = '{32'h3000_0008, 32'h3000_000C, 5'd17, 32'h5555_5555, 1'b1, 12'h000,       1'b0, 32'h0,        1'b0, 1'b0, 32'h3000_000C, 5'd1,  32'h0,         5'd17, 32'h0,        CSR_MSTATUS,   32'h1800,     CSR_MTVEC,     32'h0};
        vec[3]  = '{32'h3000_000C, 32'h3000_0010, 5'd3,  32'h3333_3333, 1'b1, 12'h000,       1'b0, 32'h0,        1'b0, 1'b0, 32'h3000_0010, 5'd3,  32'h3333_3333, 5'd5,  32'hDEAD_BEEF, CSR_MTVEC,     32'h0,        CSR_MEPC,      32'h0};
        vec[4]  = '{32'h3000_0010, 32'h3000_0014, 5'd4,  32'h0000_0044, 1'b1, CSR_MTVEC,     1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h3000_0014, 5'd4,  32'h0000_0044, 5'd3,  32'h3333_3333, CSR_MTVEC,     32'h8000_0100, CSR_MSTATUS,   32'h1800};
        vec[5]  = '{32'h8000_0040, 32'h8000_0044, 5'd3,  32'h0000_FFFF, 1'b1, CSR_MSTATUS,   1'b1, 32'h0,        1'b1, 1'b0, 32'h8000_0100, 5'd3,  32'h3333_3333, 5'd4,  32'h0000_0044, CSR_MEPC,      32'h8000_0040, CSR_MCAUSE,    32'd11};
        vec[6]  = '{32'h8000_0100, 32'h8000_0104, 5'd6,  32'h0000_0066, 1'b1, CSR_MCAUSE,    1'b1, 32'h0000_0007, 1'b0, 1'b1, 32'h8000_0040, 5'd6,  32'h0,         5'd3,  32'h3333_3333, CSR_MCAUSE,    32'h0000_0007, CSR_MSTATUS,   32'h1800};
        vec[7]  = '{32'h8000_0044, 32'h8000_0048, 5'd0,  32'h0,        1'b0, 12'h000,       1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_0100, 5'd5,  32'hDEAD_BEEF, 5'd0,  32'h0,        CSR_MEPC,      32'h8000_0044, CSR_MCAUSE,    32'd11};
        vec[8]  = '{32'h8000_0100, 32'h3000_0018, 5'd0,  32'h0,        1'b0, CSR_MVENDORID, 1'b1, 32'h0,        1'b0, 1'b0, 32'h3000_0018, 5'd0,  32'h0,         5'd0,  32'h0,        CSR_MVENDORID, 32'h7973_7978, CSR_MARCHID,   32'd24080006};
        vec[9]  = '{32'h3000_0018, 32'h3000_001C, 5'd0,  32'h0,        1'b0, 12'h7C0,       1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h3000_001C, 5'd0,  32'h0,         5'd0,  32'h0,        12'h7C0,       32'h0,        CSR_MTVEC,     32'h8000_0100};
        vec[10] = '{32'h3000_001C, 32'h3000_0020, 5'd0,  32'h0,        1'b0, CSR_MEPC,      1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h3000_0020, 5'd0,  32'h0,         5'd0,  32'h0,        CSR_MEPC,      32'h1234_5678, CSR_MCAUSE,    32'd11};
        vec[11] = '{32'h3000_0020, 32'h3000_0024, 5'd0,  32'h0,        1'b0, 12'h000,       1'b0, 32'h0,        1'b0, 1'b1, 32'h1234_5678, 5'd0,  32'h0,         5'd0,  32'h0,        CSR_MEPC,      32'h1234_5678, CSR_MSTATUS,   32'h1800};

        idle_v = '{32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 12'h000, 1'b0, 32'h0, 1'b0, 1'b0,
                   32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 12'h000, 32'h0, 12'h000, 32'h0};
        applyStimulus(idle_v);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        csr_raddr = 12'h000;
        reset     = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Boot: the reset PC is offered and held while the IFU stalls.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            checkOutput($sformatf("boot%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("boot%0d_npc", c), out_npc, 32'h3000_0000);
            checkOutput($sformatf("boot%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
        end
        releaseDone("boot");
        checkOutput("boot_out_valid_after", {31'd0, out_valid}, 32'd0);

        // Table of single commits, each followed by an IFU accept.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vec[i]);
            in_valid = 1'b1;
            @(negedge clock);
            in_valid = 1'b0;
            rs2_addr = vec[i].rs2a;
            readGpr(vec[i].rs1a, d);
            checkOutput($sformatf("v%0d_rs1", i), d, vec[i].exp_rs1);
            checkOutput($sformatf("v%0d_rs2", i), rs2_data, vec[i].exp_rs2);
            checkOutput($sformatf("v%0d_npc", i), out_npc, vec[i].exp_npc);
            checkOutput($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
            readCsr(vec[i].csra, d);
            checkOutput($sformatf("v%0d_csra", i), d, vec[i].exp_csra);
            readCsr(vec[i].csrb, d);
            checkOutput($sformatf("v%0d_csrb", i), d, vec[i].exp_csrb);
            releaseDone($sformatf("v%0d", i));
        end

        // Commit-cycle reads return the old GPR/CSR values.
        applyStimulus(idle_v);
        in_rd_addr   = 5'd5;
        in_wdata     = 32'h0BAD_0BAD;
        in_wb        = 1'b1;
        in_csr_addr  = CSR_MTVEC;
        in_csr_we    = 1'b1;
        in_csr_wdata = 32'hAAAA_0000;
        in_dnpc      = 32'h3000_0200;
        in_valid     = 1'b1;
        readCsr(CSR_MTVEC, d);
        checkOutput("pre_mtvec_old", d, 32'h8000_0100);
        readGpr(5'd5, d);
        checkOutput("pre_x5_old", d, 32'hDEAD_BEEF);
        @(negedge clock);
        in_valid = 1'b0;
        readCsr(CSR_MTVEC, d);
        checkOutput("post_mtvec_new", d, 32'hAAAA_0000);
        readGpr(5'd5, d);
        checkOutput("post_x5_new", d, 32'h0BAD_0BAD);
        checkOutput("post_npc", out_npc, 32'h3000_0200);
        releaseDone("pre");

        // Backpressure: DONE ignores in_valid while the IFU stalls.
        applyStimulus(idle_v);
        in_rd_addr = 5'd7;
        in_wdata   = 32'h0000_0077;
        in_wb      = 1'b1;
        in_dnpc    = 32'h3000_0300;
        in_valid   = 1'b1;
        @(negedge clock);
        for (int c = 0; c < 5; c++) begin
            in_wdata     = 32'h1000 + 32'(c);
            in_dnpc      = 32'h4000_0000 + 32'(c);
            in_csr_addr  = CSR_MTVEC;
            in_csr_we    = 1'b1;
            in_csr_wdata = 32'h5000 + 32'(c);
            in_valid     = 1'b1;
            @(negedge clock);
            readGpr(5'd7, d);
            checkOutput($sformatf("bp%0d_x7", c), d, 32'h0000_0077);
            checkOutput($sformatf("bp%0d_npc", c), out_npc, 32'h3000_0300);
            checkOutput($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            readCsr(CSR_MTVEC, d);
            checkOutput($sformatf("bp%0d_mtvec", c), d, 32'hAAAA_0000);
        end

        // Reset while parked in DONE returns to BOOT with clean architectural state.
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_npc", out_npc, 32'h3000_0000);
        readGpr(5'd5, d);
        checkOutput("rst_x5", d, 32'h0);
        readGpr(5'd7, d);
        checkOutput("rst_x7", d, 32'h0);
        readCsr(CSR_MSTATUS, d);
        checkOutput("rst_mstatus", d, 32'h1800);
        readCsr(CSR_MTVEC, d);
        checkOutput("rst_mtvec", d, 32'h0);
        readCsr(CSR_MEPC, d);
        checkOutput("rst_mepc", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
